// File: rtl/axis_width_upsizer_if.sv
// AXI4-Stream bundle shared by the narrow input side and the wide output side
// of the width upsizer. The slave view carries no tkeep because the narrow
// input beats are always fully populated.
interface axis_width_upsizer_if #(
  parameter int DATA_W = 32
) ();
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_width_upsizer.sv
// AXI4-Stream width upsizer: packs R = OUT_WIDTH/IN_WIDTH narrow beats into one
// wide word. One accumulator stage plus one registered output stage, so up to
// 2R beats can be buffered while the consumer stalls. Early tlast or flush emit
// a partial word whose unfilled lanes are zero and whose tkeep covers only the
// filled lanes.
module axis_width_upsizer #(
  parameter int IN_WIDTH       = 32,
  parameter int OUT_WIDTH      = 256,
  parameter int FIRST_BEAT_LSB = 1
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_aresetn,
  input  logic                 flush,
  axis_width_upsizer_if.slave  s00_axis,
  axis_width_upsizer_if.master m00_axis
);
  localparam int R  = OUT_WIDTH / IN_WIDTH;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam int KW = OUT_WIDTH / 8;
  localparam int LB = IN_WIDTH / 8;

  // Accumulator stage
  logic [OUT_WIDTH-1:0] r_acc_data;
  logic [KW-1:0]        r_acc_keep;
  logic [CW-1:0]        r_acc_cnt;
  logic                 r_acc_full;
  logic                 r_acc_last;

  // Output register stage
  logic [OUT_WIDTH-1:0] r_m_data;
  logic [KW-1:0]        r_m_keep;
  logic                 r_m_valid;
  logic                 r_m_last;

  // Handshake qualifiers
  logic w_xfer;
  logic w_ready;
  logic w_accept;

  // Accumulator as seen after an optional same-cycle transfer
  logic [OUT_WIDTH-1:0] w_base_data;
  logic [KW-1:0]        w_base_keep;
  logic [CW-1:0]        w_base_cnt;
  logic                 w_base_full;
  logic                 w_base_last;

  // Next accumulator contents
  logic [OUT_WIDTH-1:0] w_nxt_data;
  logic [KW-1:0]        w_nxt_keep;
  logic [CW-1:0]        w_nxt_cnt;
  logic                 w_nxt_full;
  logic                 w_nxt_last;

  // Physical lane index of logical beat k, honouring the beat ordering.
  function automatic int lane_pos(input int k);
    if (FIRST_BEAT_LSB != 0) begin
      lane_pos = k;
    end else begin
      lane_pos = R - 1 - k;
    end
  endfunction

  assign w_xfer   = r_acc_full && (!r_m_valid || m00_axis.tready);
  assign w_ready  = s00_axis_aresetn && (!r_acc_full || !r_m_valid || m00_axis.tready);
  assign w_accept = s00_axis.tvalid && w_ready;

  assign s00_axis.tready = w_ready;
  assign m00_axis.tdata  = r_m_data;
  assign m00_axis.tkeep  = r_m_keep;
  assign m00_axis.tvalid = r_m_valid;
  assign m00_axis.tlast  = r_m_last;

  // Next accumulator state: clear on transfer, then merge the accepted beat and
  // decide whether this cycle completes the word (lane R-1, tlast or flush).
  always_comb begin
    w_base_data = w_xfer ? {OUT_WIDTH{1'b0}} : r_acc_data;
    w_base_keep = w_xfer ? {KW{1'b0}}        : r_acc_keep;
    w_base_cnt  = w_xfer ? {CW{1'b0}}        : r_acc_cnt;
    w_base_full = w_xfer ? 1'b0              : r_acc_full;
    w_base_last = w_xfer ? 1'b0              : r_acc_last;

    w_nxt_data = w_base_data;
    w_nxt_keep = w_base_keep;
    w_nxt_cnt  = w_base_cnt;
    w_nxt_full = w_base_full;
    w_nxt_last = w_base_last;

    if (w_accept) begin
      for (int k = 0; k < R; k++) begin
        w_nxt_data[lane_pos(k)*IN_WIDTH +: IN_WIDTH] =
          (CW'(k) == w_base_cnt) ? s00_axis.tdata
                                 : w_base_data[lane_pos(k)*IN_WIDTH +: IN_WIDTH];
        w_nxt_keep[lane_pos(k)*LB +: LB] =
          (CW'(k) == w_base_cnt) ? {LB{1'b1}}
                                 : w_base_keep[lane_pos(k)*LB +: LB];
      end
      w_nxt_cnt  = w_base_cnt + CW'(1);
      w_nxt_last = s00_axis.tlast;
      w_nxt_full = (w_base_cnt == CW'(R - 1)) || s00_axis.tlast || flush;
    end else if (flush && (w_base_cnt != {CW{1'b0}}) && !w_base_full) begin
      // Flush of a partial word keeps acc_last as it was.
      w_nxt_full = 1'b1;
    end else begin
      w_nxt_full = w_base_full;
    end
  end

  // Accumulator registers.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_acc_data <= {OUT_WIDTH{1'b0}};
      r_acc_keep <= {KW{1'b0}};
      r_acc_cnt  <= {CW{1'b0}};
      r_acc_full <= 1'b0;
      r_acc_last <= 1'b0;
    end else begin
      r_acc_data <= w_nxt_data;
      r_acc_keep <= w_nxt_keep;
      r_acc_cnt  <= w_nxt_cnt;
      r_acc_full <= w_nxt_full;
      r_acc_last <= w_nxt_last;
    end
  end

  // Output register: load on transfer, drop valid once the consumer takes it.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_m_data  <= {OUT_WIDTH{1'b0}};
      r_m_keep  <= {KW{1'b0}};
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_xfer) begin
      r_m_data  <= r_acc_data;
      r_m_keep  <= r_acc_keep;
      r_m_valid <= 1'b1;
      r_m_last  <= r_acc_last;
    end else if (r_m_valid && m00_axis.tready) begin
      r_m_valid <= 1'b0;
    end else begin
      r_m_valid <= r_m_valid;
    end
  end
endmodule

// File: tb/tb_axis_width_upsizer.sv
// Self-checking bench for axis_width_upsizer (IN=32, OUT=128). Two DUTs share
// one input stream: one with LSB-first beat ordering, one with MSB-first. A
// packet-level reference model builds expected words into per-DUT queues and
// independent monitors pop and compare on every output handshake.
module tb_axis_width_upsizer;
  localparam int IW = 32;
  localparam int OW = 128;
  localparam int R  = OW / IW;

  typedef struct {
    logic [OW-1:0]   d;
    logic [OW/8-1:0] k;
    logic            l;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic rnd   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out0  = 0;

  logic [IW-1:0] part[$];
  word_t         q0[$];
  word_t         q1[$];

  always #5 clk = ~clk;

  axis_width_upsizer_if #(.DATA_W(IW)) s0 ();
  axis_width_upsizer_if #(.DATA_W(IW)) s1 ();
  axis_width_upsizer_if #(.DATA_W(OW)) m0 ();
  axis_width_upsizer_if #(.DATA_W(OW)) m1 ();

  assign s1.tdata  = s0.tdata;
  assign s1.tvalid = s0.tvalid;
  assign s1.tlast  = s0.tlast;
  assign s1.tkeep  = s0.tkeep;
  assign m1.tready = m0.tready;

  axis_width_upsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .FIRST_BEAT_LSB(1)) dut0 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .flush(flush),
    .s00_axis(s0.slave), .m00_axis(m0.master));

  axis_width_upsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .FIRST_BEAT_LSB(0)) dut1 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .flush(flush),
    .s00_axis(s1.slave), .m00_axis(m1.master));

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: build both orderings of the current partial packet and queue them.
  function automatic void emit(input logic last);
    word_t w0;
    word_t w1;
    w0.d = '0; w0.k = '0; w0.l = last;
    w1.d = '0; w1.k = '0; w1.l = last;
    for (int k = 0; k < part.size(); k++) begin
      w0.d = w0.d | (OW'(part[k]) << (IW * k));
      w1.d = w1.d | (OW'(part[k]) << (OW - IW * (k + 1)));
      w0.k = w0.k | (16'h000F << (4 * k));
      w1.k = w1.k | (16'h000F << (16 - 4 * (k + 1)));
    end
    q0.push_back(w0);
    q1.push_back(w1);
    part.delete();
  endfunction

  // Reference model: observes input handshakes and flush, one cycle at a time.
  always @(negedge clk) begin
    if (!rst_n) begin
      part.delete();
      q0.delete();
      q1.delete();
    end else if (s0.tvalid && s0.tready) begin
      part.push_back(s0.tdata);
      if (part.size() == R || s0.tlast) emit(s0.tlast);
      else if (flush) emit(1'b0);
    end else if (flush && part.size() > 0) begin
      emit(1'b0);
    end
  end

  // Monitor for the LSB-first DUT.
  always @(negedge clk) begin
    if (rst_n && m0.tvalid && m0.tready) begin
      n_out0++;
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL lsb unexpected word: got %h expected none", m0.tdata);
      end else begin
        word_t w;
        w = q0.pop_front();
        chk("lsb tdata", m0.tdata, w.d);
        chk("lsb tkeep", OW'(m0.tkeep), OW'(w.k));
        chk("lsb tlast", OW'(m0.tlast), OW'(w.l));
      end
    end
  end

  // Monitor for the MSB-first DUT.
  always @(negedge clk) begin
    if (rst_n && m1.tvalid && m1.tready) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL msb unexpected word: got %h expected none", m1.tdata);
      end else begin
        word_t w;
        w = q1.pop_front();
        chk("msb tdata", m1.tdata, w.d);
        chk("msb tkeep", OW'(m1.tkeep), OW'(w.k));
        chk("msb tlast", OW'(m1.tlast), OW'(w.l));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) m0.tready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [IW-1:0] d, input logic last, input logic fl, output int waits);
    logic got;
    got = 1'b0;
    waits = 0;
    s0.tdata = d; s0.tlast = last; s0.tvalid = 1'b1; flush = fl;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = s0.tready;
      step();
      if (!got) waits++;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL send timeout: got no handshake expected one for %h", d);
    end
    s0.tvalid = 1'b0; s0.tlast = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    int w, wsum, n, old;
    logic got;
    s0.tdata = '0; s0.tvalid = 1'b0; s0.tlast = 1'b0; s0.tkeep = 4'hF;
    m0.tready = 1'b1;

    // Reset state
    #1;
    chk("reset tvalid", OW'(m0.tvalid), '0);
    chk("reset tdata", m0.tdata, '0);
    chk("reset tkeep", OW'(m0.tkeep), '0);
    chk("reset s_tready", OW'(s0.tready), '0);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("s_tready after reset", OW'(s0.tready), 128'd1);

    // Scenario 1: full packet, always ready
    wsum = 0;
    send(32'h11111111, 1'b0, 1'b0, w); wsum += w;
    send(32'h22222222, 1'b0, 1'b0, w); wsum += w;
    send(32'h33333333, 1'b0, 1'b0, w); wsum += w;
    send(32'h44444444, 1'b1, 1'b0, w); wsum += w;
    chk("s1 no stall", OW'(wsum), '0);
    chk("s1 tvalid before xfer", OW'(m0.tvalid), '0);
    step();
    chk("s1 tvalid after xfer", OW'(m0.tvalid), 128'd1);
    chk("s1 lsb data", m0.tdata, 128'h44444444_33333333_22222222_11111111);
    chk("s1 keep", OW'(m0.tkeep), 128'hFFFF);
    chk("s1 last", OW'(m0.tlast), 128'd1);
    chk("s5 msb data", m1.tdata, 128'h11111111_22222222_33333333_44444444);
    idle(2);

    // Scenario 2: early tlast
    send(32'h0000000A, 1'b0, 1'b0, w);
    send(32'h0000000B, 1'b1, 1'b0, w);
    step();
    chk("s2 data", m0.tdata, 128'h00000000_00000000_0000000B_0000000A);
    chk("s2 keep", OW'(m0.tkeep), 128'h00FF);
    chk("s2 last", OW'(m0.tlast), 128'd1);
    idle(2);

    // Scenario 3: flush, then flush with empty accumulator
    send(32'hC0000001, 1'b0, 1'b0, w);
    send(32'hC0000002, 1'b0, 1'b0, w);
    send(32'hC0000003, 1'b0, 1'b0, w);
    pulse_flush();
    step();
    chk("s3 keep", OW'(m0.tkeep), 128'h0FFF);
    chk("s3 last", OW'(m0.tlast), '0);
    idle(2);
    old = n_out0;
    pulse_flush();
    idle(5);
    chk("s3 empty flush no word", OW'(n_out0), OW'(old));
    chk("s3 empty flush tvalid", OW'(m0.tvalid), '0);

    // Scenario 4: backpressure, 12 beats offered
    m0.tready = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      s0.tvalid = (n < 12);
      s0.tdata  = 32'h100 + n;
      s0.tlast  = (n == 11);
      @(negedge clk);
      got = s0.tready && s0.tvalid;
      @(posedge clk); #1;
      if (got) n++;
    end
    s0.tvalid = 1'b0; s0.tlast = 1'b0;
    chk("s4 beats accepted", OW'(n), 128'd8);
    chk("s4 s_tready held low", OW'(s0.tready), '0);
    m0.tready = 1'b1;
    for (int i = n; i < 12; i++) send(32'h100 + i, (i == 11), 1'b0, w);
    idle(6);

    // Scenario 6: reset with a word pending and two beats accumulated
    m0.tready = 1'b0;
    for (int i = 0; i < 6; i++) send(32'hDEAD0000 + i, 1'b0, 1'b0, w);
    #3 rst_n = 1'b0;
    #1;
    chk("s6 tvalid", OW'(m0.tvalid), '0);
    chk("s6 tdata", m0.tdata, '0);
    chk("s6 tkeep", OW'(m0.tkeep), '0);
    chk("s6 tlast", OW'(m0.tlast), '0);
    chk("s6 s_tready", OW'(s0.tready), '0);
    @(posedge clk); #1; rst_n = 1'b1; m0.tready = 1'b1;
    for (int i = 0; i < 4; i++) send(32'hBEEF0000 + i, (i == 3), 1'b0, w);
    step();
    chk("s6 fresh word", m0.tdata, 128'hBEEF0003_BEEF0002_BEEF0001_BEEF0000);
    idle(3);

    // Randomized traffic with random backpressure, tlast and flush
    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) pulse_flush();
      else send($urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 12) == 0), w);
    end
    rnd = 1'b0;
    m0.tready = 1'b1;
    pulse_flush();
    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) step();
    chk("drain lsb queue", OW'(q0.size()), '0);
    chk("drain msb queue", OW'(q1.size()), '0);
    chk("drain partial", OW'(part.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_width_upsizer.md
# axis_width_upsizer

Parametrised AXI4-Stream width upsizer: packs `R = OUT_WIDTH/IN_WIDTH` narrow input beats into one wide output beat. It supports:
- full backpressure on both sides;
- packet boundaries via `tlast`, with partial words emitted on early `tlast` or `flush` and marked by `tkeep`;
- selectable beat ordering.

It succeeds the fixed 32-bit always-ready shift-register converter and sits between the 32-bit DMA stream and wide-datapath consumers.

## Interface
- `IN_WIDTH`, 32, input beat width in bits; multiple of 8.
- `OUT_WIDTH`, 256, output word width in bits; integer multiple of `IN_WIDTH`, with `R >= 2`.
- `FIRST_BEAT_LSB`, 1:
  - 1: beat k occupies `tdata[k*IN_WIDTH +: IN_WIDTH]`.
  - 0: beat k occupies `tdata[OUT_WIDTH-(k+1)*IN_WIDTH +: IN_WIDTH]`.
- `s00_axis_aclk`  in  1  the single clock; all logic is on its rising edge.
- `s00_axis_aresetn`  in  1  reset; asynchronous, active-low.
- `s00_axis_tdata`  in  `IN_WIDTH`  input beat data.
- `s00_axis_tvalid`  in  1  input beat valid.
- `s00_axis_tready`  out  1  input ready.
- `s00_axis_tlast`  in  1  last beat of the packet.
- `flush`  in  1  force emission of the partially filled word.
- `m00_axis_tdata`  out  `OUT_WIDTH`  packed output word.
- `m00_axis_tkeep`  out  `OUT_WIDTH/8`  byte enables of the valid lanes.
- `m00_axis_tvalid`  out  1  output valid.
- `m00_axis_tready`  in  1  output ready.
- `m00_axis_tlast`  out  1  output word ends the packet.

## Operation
- Two storage stages: an accumulator (`acc_data`, `acc_cnt` 0..R-1, `acc_full`, `acc_last`) and an output register (the `m00_*` outputs).
- An input beat is accepted when `s00_axis_tvalid && s00_axis_tready`. On acceptance:
  - the beat is written to lane `acc_cnt`;
  - `acc_cnt` increments.
- Word completion is set when any of the following holds, and sets `acc_full`:
  - the accepted beat fills lane R-1;
  - the accepted beat has `tlast=1` (`acc_last` is set);
  - `flush=1` with `acc_cnt>0` (or a beat accepted this cycle), in which case `acc_last` is unchanged.
- Unfilled lanes of a partial word are 0. `tkeep` is 1 for exactly the bytes of filled lanes.
- Transfer from accumulator to output happens when `acc_full && (!m00_axis_tvalid || m00_axis_tready)`. On transfer:
  - data, keep and last are loaded into the output register;
  - `m00_axis_tvalid` is set to 1;
  - the accumulator is cleared (`acc_cnt=0`, `acc_full=0`).
- If a new beat is accepted in the same cycle as a transfer, it is written to lane 0 of the freshly cleared accumulator.
- `s00_axis_tready = s00_axis_aresetn && (!acc_full || !m00_axis_tvalid || m00_axis_tready)`.
  - This is a combinational path from `m00_axis_tready`; it is permitted.
- `m00_axis_tvalid` clears when the output handshake completes and no transfer occurs in the same cycle.
- Output signals are stable while `tvalid && !tready` (AXI rule).
- `flush` with an empty accumulator (`acc_cnt==0`, no beat this cycle) is ignored and produces no zero-length word.
- `flush` while `acc_full` is already set is ignored.
- `tlast` on beat R-1 produces a full word with `m00_axis_tlast=1`.

## Timing
- Reset assertion, asynchronous:
  - `m00_axis_tvalid`, `m00_axis_tlast`, `m00_axis_tdata`, `m00_axis_tkeep` = 0;
  - `acc_cnt=0`, `acc_full=0`;
  - `s00_axis_tready=0` while reset is asserted, and 1 in the first cycle after deassertion.
- Reset mid-packet discards the accumulated beats and any pending output word.
- Latency: a completing beat accepted at edge t sets `acc_full` after t. With the output free, the word is transferred at edge t+1 and `m00_axis_tvalid=1` from t+1.
- Throughput: one input beat per cycle sustained while `m00_axis_tready=1`; one output word every R cycles.
- Backpressure:
  - With the output held, the accumulator continues filling.
  - Once `acc_full`, `s00_axis_tready=0` until the output slot frees.
  - Maximum buffered data is 2R beats.

## Test plan
Configuration for all scenarios: `IN_WIDTH=32`, `OUT_WIDTH=128`, `FIRST_BEAT_LSB=1`, unless stated.

1. Continuous stream, always ready:
   - Stimulus: beats `0x11111111`, `0x22222222`, `0x33333333`, `0x44444444` (last on 4th).
   - Required: one output word `0x44444444_33333333_22222222_11111111`, `tkeep=0xFFFF`, `tlast=1`, `tvalid` one cycle after `acc_full`; `s00_axis_tready` stays 1.
2. Early `tlast`:
   - Stimulus: beats `0xA`, `0xB` with `tlast` on `0xB`.
   - Required: `tdata=0x00000000_00000000_0000000B_0000000A`, `tkeep=0x00FF`, `tlast=1`; the next packet starts at lane 0.
3. Flush:
   - Stimulus: 3 beats, then `flush` pulse.
   - Required: word with `tkeep=0x0FFF`, `tlast=0`. A second `flush` with the accumulator empty produces no output.
4. Backpressure:
   - Stimulus: hold `m00_axis_tready=0` and stream 12 beats.
   - Required: exactly 8 beats accepted, then `s00_axis_tready=0`. On releasing ready, words 1, 2 and 3 emerge in order with no loss or duplication.
5. `FIRST_BEAT_LSB=0`:
   - Stimulus: the same as scenario 1.
   - Required: `tdata=0x11111111_22222222_33333333_44444444`.
6. Reset mid-operation:
   - Stimulus: assert `s00_axis_aresetn` low asynchronously after 2 beats, with an output word pending.
   - Required: all outputs 0 immediately; after release, a fresh 4-beat packet yields only its own word.
